// File: rtl/foo_pipeline_rv.sv
// foo_pipeline_rv: a three-stage valid/ready pipeline that computes
// out = (x + 3) mod 2^WIDTH. Stage 0 adds 1 to the whole word. Stage 1 adds 1
// to the upper WIDTH-1 bits and passes bit 0 through, which adds 2.
// Each stage moves forward when the stage after it is empty or is draining
// in the same cycle, so a full pipeline with no stall still accepts one
// item per cycle.
module foo_pipeline_rv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [1:0]       occupancy
);

  // Stage 1 has to split the word into bit 0 and at least one upper bit.
  if (WIDTH < 2) begin : g_width_check
    $error("foo_pipeline_rv: WIDTH must be >= 2");
  end

  logic [WIDTH-1:0] p0_data_q, p0_data_d;
  logic [WIDTH-1:0] p1_data_q, p1_data_d;
  logic [WIDTH-1:0] p2_data_q, p2_data_d;
  logic             p0_valid_q, p0_valid_d;
  logic             p1_valid_q, p1_valid_d;
  logic             p2_valid_q, p2_valid_d;

  logic             adv0, adv1, adv2;
  logic [WIDTH-1:0] s0_result, s1_result;

  // Compute advance conditions from the output end back to the input.
  always_comb begin
    adv2     = p2_valid_q & out_ready;
    adv1     = ~p2_valid_q | adv2;
    adv0     = ~p1_valid_q | adv1;
    in_ready = ~p0_valid_q | adv0;
  end

  // Stage arithmetic. Bit 0 passes through stage 1 unchanged.
  always_comb begin
    s0_result = p0_data_q + WIDTH'(1);
    s1_result = {p1_data_q[WIDTH-1:1] + (WIDTH-1)'(1), p1_data_q[0]};
  end

  // Next-state logic. Each stage holds unless it is allowed to advance. When
  // a stage advances, it copies the valid bit from the stage before it, so a
  // stage that empties with nothing behind it clears its valid bit.
  always_comb begin
    p0_data_d  = p0_data_q;
    p0_valid_d = p0_valid_q;
    p1_data_d  = p1_data_q;
    p1_valid_d = p1_valid_q;
    p2_data_d  = p2_data_q;
    p2_valid_d = p2_valid_q;
    if (in_ready) begin
      p0_data_d  = x;
      p0_valid_d = in_valid;
    end
    if (adv0) begin
      p1_data_d  = s0_result;
      p1_valid_d = p0_valid_q;
    end
    if (adv1) begin
      p2_data_d  = s1_result;
      p2_valid_d = p1_valid_q;
    end
  end

  // Stage registers. Reset clears them immediately and drops any items still
  // in the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_data_q  <= '0;
      p1_data_q  <= '0;
      p2_data_q  <= '0;
      p0_valid_q <= 1'b0;
      p1_valid_q <= 1'b0;
      p2_valid_q <= 1'b0;
    end else begin
      p0_data_q  <= p0_data_d;
      p1_data_q  <= p1_data_d;
      p2_data_q  <= p2_data_d;
      p0_valid_q <= p0_valid_d;
      p1_valid_q <= p1_valid_d;
      p2_valid_q <= p2_valid_d;
    end
  end

  // The outputs come straight from registers. Occupancy is the number of
  // valid stages.
  always_comb begin
    out       = p2_data_q;
    out_valid = p2_valid_q;
    occupancy = {1'b0, p0_valid_q} + {1'b0, p1_valid_q} + {1'b0, p2_valid_q};
  end

endmodule

// File: tb/tb_foo_pipeline_rv.sv
// Bench for foo_pipeline_rv. It drives a WIDTH=32 instance and a WIDTH=2
// instance, one at a time. The reference model is a FIFO of expected results:
// every accepted x pushes (x+3) mod 2^WIDTH, and every output handshake pops
// the front entry and compares it with out.
module tb_foo_pipeline_rv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
  logic [31:0] a_x = '0, a_out;
  logic [1:0]  a_occ;

  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
  logic [1:0]  b_x = '0, b_out;
  logic [1:0]  b_occ;

  always #5 clk = ~clk;

  foo_pipeline_rv #(.WIDTH(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .x(a_x), .out_valid(a_out_valid), .out_ready(a_out_ready), .out(a_out),
    .occupancy(a_occ));

  foo_pipeline_rv #(.WIDTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .x(b_x), .out_valid(b_out_valid), .out_ready(b_out_ready), .out(b_out),
    .occupancy(b_occ));

  typedef struct {
    logic        iv;
    logic [31:0] xv;
    logic        ordy;
    logic        e_ov;
    logic [31:0] e_out;
    logic [1:0]  e_occ;
    logic        e_ir;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          sel = 0;          // 0 drives dut_a, 1 drives dut_b
  logic [31:0] model_q[$];       // expected results, oldest first
  logic [31:0] got[$];           // values seen at output handshakes
  int          in_count = 0, out_count = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_out = '0;
  logic        s_ir, s_ov;
  logic [31:0] s_out;
  logic [1:0]  s_occ;
  vec_t        tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (dut %0d): got %0h expected %0h", name, sel, act, exp);
    end
  endtask

  task automatic sample();
    if (sel == 0) begin
      s_ir = a_in_ready; s_ov = a_out_valid; s_out = a_out; s_occ = a_occ;
    end else begin
      s_ir = b_in_ready; s_ov = b_out_valid; s_out = {30'b0, b_out}; s_occ = b_occ;
    end
  endtask

  // Runs one cycle. Inputs are applied at the falling edge and outputs are
  // sampled 1 time unit later. The model is then checked and updated with
  // the handshakes that will take place at the next rising edge.
  task automatic step(input logic iv, input logic [31:0] xv, input logic ordy);
    logic [31:0] mask;
    mask = (sel == 0) ? 32'hFFFF_FFFF : 32'h3;
    @(negedge clk);
    if (sel == 0) begin
      a_in_valid = iv; a_x = xv; a_out_ready = ordy;
      b_in_valid = 1'b0; b_out_ready = 1'b0;
    end else begin
      b_in_valid = iv; b_x = xv[1:0]; b_out_ready = ordy;
      a_in_valid = 1'b0; a_out_ready = 1'b0;
    end
    #1;
    sample();
    chk("occupancy", {30'b0, s_occ}, model_q.size());
    chk("in_ready", {31'b0, s_ir}, {31'b0, !(model_q.size() == 3 && !ordy)});
    if (prev_stall) begin
      chk("stall_valid", {31'b0, s_ov}, 32'd1);
      chk("stall_out", s_out, prev_out);
    end
    if (model_q.size() == 0) chk("valid_when_empty", {31'b0, s_ov}, 32'd0);
    else if (s_ov) chk("out_order", s_out, model_q[0]);
    if (s_ov && ordy) begin
      got.push_back(s_out);
      if (model_q.size() != 0) void'(model_q.pop_front());
      out_count++;
    end
    if (iv && s_ir) begin
      model_q.push_back(((xv & mask) + 32'd3) & mask);
      in_count++;
    end
    prev_stall = s_ov && !ordy;
    prev_out = s_out;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && model_q.size() != 0; i++) step(1'b0, '0, 1'b1);
    chk("drain_empty", model_q.size(), 32'd0);
  endtask

  task automatic add(input logic iv, input logic [31:0] xv, input logic ordy,
                     input logic e_ov, input logic [31:0] e_out,
                     input logic [1:0] e_occ, input logic e_ir);
    vec_t v;
    v.iv = iv; v.xv = xv; v.ordy = ordy;
    v.e_ov = e_ov; v.e_out = e_out; v.e_occ = e_occ; v.e_ir = e_ir;
    tbl.push_back(v);
  endtask

  initial begin
    int in0, out0;
    // streaming 0,1,2
    add(1, 0, 1, 0, 0, 0, 1);
    add(1, 1, 1, 0, 0, 1, 1);
    add(1, 2, 1, 0, 0, 2, 1);
    add(0, 0, 1, 1, 3, 3, 1);
    add(0, 0, 1, 1, 4, 2, 1);
    add(0, 0, 1, 1, 5, 1, 1);
    add(0, 0, 1, 0, 0, 0, 1);
    // wraparound
    add(1, 32'hFFFF_FFFF, 1, 0, 0, 0, 1);
    add(1, 32'hFFFF_FFFE, 1, 0, 0, 1, 1);
    add(0, 0, 1, 0, 0, 2, 1);
    add(0, 0, 1, 1, 32'h2, 2, 1);
    add(0, 0, 1, 1, 32'h1, 1, 1);
    add(0, 0, 1, 0, 0, 0, 1);
    // backpressure with five items offered
    add(1, 10, 0, 0, 0, 0, 1);
    add(1, 11, 0, 0, 0, 1, 1);
    add(1, 12, 0, 0, 0, 2, 1);
    add(1, 13, 0, 1, 13, 3, 0);
    add(1, 13, 0, 1, 13, 3, 0);
    add(1, 13, 1, 1, 13, 3, 1);
    add(1, 14, 1, 1, 14, 3, 1);
    add(0, 0, 1, 1, 15, 3, 1);
    add(0, 0, 1, 1, 16, 2, 1);
    add(0, 0, 1, 1, 17, 1, 1);
    add(0, 0, 1, 0, 0, 0, 1);

    // Check the reset values while reset is held.
    repeat (3) @(negedge clk);
    #1;
    sel = 0; sample();
    chk("rst_ready", {31'b0, s_ir}, 32'd1);
    chk("rst_valid", {31'b0, s_ov}, 32'd0);
    chk("rst_out", s_out, 32'd0);
    chk("rst_occ", {30'b0, s_occ}, 32'd0);
    sel = 1; sample();
    chk("rst_valid", {31'b0, s_ov}, 32'd0);
    chk("rst_occ", {30'b0, s_occ}, 32'd0);
    sel = 0;
    rst_n = 1'b1;

    // Apply the table vectors.
    foreach (tbl[i]) begin
      step(tbl[i].iv, tbl[i].xv, tbl[i].ordy);
      chk("tbl_valid", {31'b0, s_ov}, {31'b0, tbl[i].e_ov});
      chk("tbl_occ", {30'b0, s_occ}, {30'b0, tbl[i].e_occ});
      chk("tbl_ready", {31'b0, s_ir}, {31'b0, tbl[i].e_ir});
      if (tbl[i].e_ov) chk("tbl_out", s_out, tbl[i].e_out);
      $display("vec %0d: iv=%0b x=%0h ordy=%0b -> ov=%0b out=%0h occ=%0d ir=%0b",
               i, tbl[i].iv, tbl[i].xv, tbl[i].ordy, s_ov, s_out, s_occ, s_ir);
    end

    // Full pass-through: fill the pipeline, then stream 10 cycles with no stall.
    for (int i = 0; i < 3; i++) step(1'b1, 32'd100 + i, 1'b0);
    in0 = in_count; out0 = out_count;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'd200 + i, 1'b1);
      chk("full_occ", {30'b0, s_occ}, 32'd3);
    end
    chk("full_in", in_count - in0, 32'd10);
    chk("full_out", out_count - out0, 32'd10);
    $display("pass-through: in=%0d out=%0d", in_count - in0, out_count - out0);
    drain();

    // Assert reset between clock edges with two items in flight.
    step(1'b1, 32'd300, 1'b0);
    step(1'b1, 32'd301, 1'b0);
    @(posedge clk);
    #3;
    a_in_valid = 1'b0;
    sample();
    chk("pre_rst_occ", {30'b0, s_occ}, 32'd2);
    rst_n = 1'b0;
    #1;
    sample();
    chk("async_valid", {31'b0, s_ov}, 32'd0);
    chk("async_occ", {30'b0, s_occ}, 32'd0);
    chk("async_ready", {31'b0, s_ir}, 32'd1);
    chk("async_out", s_out, 32'd0);
    $display("async reset: ov=%0b occ=%0d ir=%0b", s_ov, s_occ, s_ir);
    model_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);

    // Random traffic on the 32-bit instance.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0));
    drain();

    // WIDTH=2 instance: inputs 0..3 produce 3,0,1,2.
    sel = 1;
    got.delete();
    for (int i = 0; i < 4; i++) step(1'b1, i, 1'b1);
    drain();
    chk("w2_count", got.size(), 32'd4);
    if (got.size() == 4) begin
      chk("w2_out0", got[0], 32'd3);
      chk("w2_out1", got[1], 32'd0);
      chk("w2_out2", got[2], 32'd1);
      chk("w2_out3", got[3], 32'd2);
      $display("width2: outs=%0d %0d %0d %0d", got[0], got[1], got[2], got[3]);
    end
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/foo_pipeline_rv.md
FOO_PIPELINE_RV -- requirements
Module: foo_pipeline_rv

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width in bits; SHALL be >= 2 (elaboration error otherwise).
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  1  upstream offers x this cycle.
REQ-005 Port: in_ready  output  1  block accepts x this cycle.
REQ-006 Port: x  input  WIDTH  input operand.
REQ-007 Port: out_valid  output  1  out holds a valid result.
REQ-008 Port: out_ready  input  1  downstream accepts out this cycle.
REQ-009 Port: out  output  WIDTH  result.
REQ-010 Port: occupancy  output  2  count of valid stage registers, 0..3.

Function
REQ-011 Three register stages SHALL exist: P0 (captures x), P1 (captures stage-0 result), P2 (captures stage-1 result); each has a data register and a valid bit.
REQ-012 Stage-0 logic SHALL compute y = P0.data + 1, truncated to WIDTH bits.
REQ-013 Stage-1 logic SHALL compute {P1.data[WIDTH-1:1] + 1 truncated to WIDTH-1 bits, P1.data[0]}; end to end, out = (x + 3) mod 2^WIDTH.
REQ-014 Handshake: an input transfer occurs when in_valid & in_ready; an output transfer occurs when out_valid & out_ready.
REQ-015 out SHALL equal P2.data and out_valid SHALL equal P2.valid, driven directly from registers.
REQ-016 adv2 = P2.valid & out_ready; stage k (k = 0, 1) SHALL advance when ~P(k+1).valid | adv(k+1).
REQ-017 in_ready SHALL equal ~P0.valid | adv0, combinationally, so a full unstalled pipeline accepts one item per cycle.
REQ-018 On advance into stage k+1, P(k+1) SHALL load the stage-k result and the P(k).valid bit.
REQ-019 When stage k is not advancing and P(k+1) is not draining, P(k+1) data and valid SHALL hold.
REQ-020 A stage whose contents move on with no new item arriving behind it SHALL clear its valid bit.
REQ-021 P0 SHALL load x with valid = in_valid whenever in_ready = 1.
REQ-022 Latency SHALL be 3 cycles from input transfer to out_valid, with no stall.
REQ-023 Throughput SHALL be 1 item per cycle with out_ready held high.
REQ-024 out and out_valid SHALL remain stable while out_valid & ~out_ready.
REQ-025 Ordering SHALL be preserved; no item SHALL be dropped or duplicated under any in_valid/out_ready pattern.
REQ-026 When full (occupancy = 3) and out_ready = 1: in the same cycle, one item SHALL leave and one new item SHALL be accepted, and occupancy SHALL stay 3.
REQ-027 occupancy SHALL equal P0.valid + P1.valid + P2.valid.
REQ-028 Arithmetic SHALL wrap modulo 2^WIDTH with no overflow flag; x = all-ones SHALL give out = 2.

Reset
REQ-029 rst_n low SHALL asynchronously clear all valid bits and all data registers to 0, independent of clk.
REQ-030 While rst_n is low: out_valid = 0, out = 0, occupancy = 0, in_ready = 1.
REQ-031 Reset asserted mid-operation SHALL discard in-flight items; none SHALL appear after release.
REQ-032 Input transfers SHALL be accepted from the first rising clk edge after rst_n deasserts.
REQ-033 Reset SHALL be released synchronously to clk (external synchroniser); the block contains no synchroniser.

Verification
REQ-034 Streaming: WIDTH=32, out_ready=1, x = 0,1,2 on consecutive cycles -> out_valid from cycle 3; out = 3,4,5 on consecutive cycles.
REQ-035 Wrap: x = 32'hFFFF_FFFF, then x = 32'hFFFF_FFFE -> out = 32'h0000_0002, then 32'h0000_0001.
REQ-036 Backpressure: out_ready = 0, 5 items offered -> in_ready drops after 3 accepted; occupancy = 3; out stays the first result; raising out_ready drains all 5 in order.
REQ-037 Full pass-through: occupancy = 3, in_valid = 1, out_ready = 1 for 10 cycles -> 10 in, 10 out, occupancy constant at 3.
REQ-038 Async reset: assert rst_n = 0 between clk edges with 2 items in flight -> out_valid and occupancy go to 0 before the next edge; no stale output after release.
REQ-039 WIDTH = 2: x = 0..3 -> out = 3,0,1,2; random valid/ready traffic matches a scoreboard model.
